// File: rtl/target_net_sequencer.sv
// Front-end sequencer for the target network: streams a tagged weight snapshot
// into the network, or serializes one state vector and waits for max Q.
module target_net_sequencer #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_sync_start,
  input  logic                                       i_src_valid,
  input  logic [DATA_WIDTH-1:0]                      i_src_weight,
  input  logic                                       i_state_valid,
  input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0] i_state,
  input  logic                                       i_result_valid,
  input  logic [DATA_WIDTH-1:0]                      i_result,
  output logic                                       o_ready,
  output logic                                       o_weight_valid,
  output logic [LAYER_WIDTH-1:0]                     o_weight_layer,
  output logic [DATA_WIDTH-1:0]                      o_weight,
  output logic                                       o_sync_done,
  output logic                                       o_data_valid,
  output logic [DATA_WIDTH-1:0]                      o_data,
  output logic                                       o_q_valid,
  output logic [DATA_WIDTH-1:0]                      o_q
);

  localparam int IN    = NUMBER_OF_INPUT_NODE;
  localparam int W1    = (IN + 1) * NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int W2    = (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1) * NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int W3    = (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1) * NUMBER_OF_OUTPUT_NODE;
  localparam int TOTAL = W1 + W2 + W3;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int IDX_W = (IN > 1) ? $clog2(IN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] CNT_L2    = CNT_W'(W1);
  localparam logic [CNT_W-1:0] CNT_L3    = CNT_W'(W1 + W2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(IN - 1);
  localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SEND,
    ST_WAIT
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]         word_cnt;
  logic [IDX_W-1:0]         send_idx;
  logic [IN*DATA_WIDTH-1:0] state_buf;
  logic [LAYER_WIDTH-1:0]   layer_code;

  logic take_sync;
  logic take_state;
  logic take_weight;
  logic last_weight;
  logic take_result;

  // Sync takes priority over a state vector offered in the same IDLE cycle.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    state_next  = state;
    take_sync   = 1'b0;
    take_state  = 1'b0;
    take_weight = 1'b0;
    last_weight = 1'b0;
    take_result = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_sync_start) begin
          take_sync  = 1'b1;
          state_next = ST_SYNC;
        end else if (i_state_valid) begin
          take_state = 1'b1;
          if (IN == 1) state_next = ST_WAIT;
          else         state_next = ST_SEND;
        end
      end
      ST_SYNC: begin
        if (i_src_valid) begin
          take_weight = 1'b1;
          if (word_cnt == CNT_LAST) begin
            last_weight = 1'b1;
            state_next  = ST_IDLE;
          end
        end
      end
      ST_SEND: begin
        if (send_idx == IDX_LAST) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_result_valid) begin
          take_result = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    layer_code = LAYER_WIDTH'(3);
    if (word_cnt < CNT_L2)      layer_code = LAYER_WIDTH'(1);
    else if (word_cnt < CNT_L3) layer_code = LAYER_WIDTH'(2);
  end

  // NOTE: state is updated with non-blocking assignments so every register in
  // the design samples pre-edge values regardless of process order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  assign o_ready = (state == ST_IDLE);

  // Word 0 leaves straight from i_state at capture, so SEND starts at index 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt       <= '0;
      send_idx       <= '0;
      o_weight_valid <= 1'b0;
      o_weight_layer <= '0;
      o_weight       <= '0;
      o_sync_done    <= 1'b0;
      o_data_valid   <= 1'b0;
      o_data         <= '0;
      o_q_valid      <= 1'b0;
      o_q            <= '0;
    end else begin
      o_weight_valid <= 1'b0;
      o_sync_done    <= 1'b0;
      o_data_valid   <= 1'b0;
      o_q_valid      <= 1'b0;

      if (take_sync) word_cnt <= '0;

      if (take_weight) begin
        o_weight_valid <= 1'b1;
        o_weight       <= i_src_weight;
        o_weight_layer <= layer_code;
        o_sync_done    <= last_weight;
        word_cnt       <= word_cnt + CNT_W'(1);
      end

      if (take_state) begin
        o_data_valid <= 1'b1;
        o_data       <= i_state[DATA_WIDTH-1:0];
        send_idx     <= IDX_FIRST;
      end

      if (state == ST_SEND) begin
        o_data_valid <= 1'b1;
        o_data       <= state_buf[send_idx*DATA_WIDTH +: DATA_WIDTH];
        send_idx     <= send_idx + IDX_W'(1);
      end

      if (take_result) begin
        o_q_valid <= 1'b1;
        o_q       <= i_result;
      end
    end
  end

  // NOTE: the capture buffer is pure data qualified by take_state, so it has
  // no reset; nothing reads it before it is written.
  always_ff @(posedge clk) begin
    if (take_state) state_buf <= i_state;
  end

endmodule

// File: tb/tb_target_net_sequencer.sv
// Directed bench for target_net_sequencer: scoreboard queues are filled as
// stimulus is driven and drained by a negedge monitor.
module tb_target_net_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_sync_start;
  logic          i_src_valid;
  logic [DW-1:0] i_src_weight;
  logic          i_state_valid;
  logic [2*DW-1:0] i_state;
  logic          i_result_valid;
  logic [DW-1:0] i_result;
  logic          o_ready;
  logic          o_weight_valid;
  logic [1:0]    o_weight_layer;
  logic [DW-1:0] o_weight;
  logic          o_sync_done;
  logic          o_data_valid;
  logic [DW-1:0] o_data;
  logic          o_q_valid;
  logic [DW-1:0] o_q;

  target_net_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .i_sync_start   (i_sync_start),
    .i_src_valid    (i_src_valid),
    .i_src_weight   (i_src_weight),
    .i_state_valid  (i_state_valid),
    .i_state        (i_state),
    .i_result_valid (i_result_valid),
    .i_result       (i_result),
    .o_ready        (o_ready),
    .o_weight_valid (o_weight_valid),
    .o_weight_layer (o_weight_layer),
    .o_weight       (o_weight),
    .o_sync_done    (o_sync_done),
    .o_data_valid   (o_data_valid),
    .o_data         (o_data),
    .o_q_valid      (o_q_valid),
    .o_q            (o_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          done;
    logic [1:0]    layer;
    logic [DW-1:0] word;
  } wexp_t;

  wexp_t         wq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] qq[$];

  int checks = 0;
  int errors = 0;
  int wcount = 0;
  int dcount = 0;
  int qcount = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] exp_layer(input int idx);
    if (idx < 96)   return 2'd1;
    if (idx < 1152) return 2'd2;
    return 2'd3;
  endfunction

  function automatic wexp_t exp_word(input int idx);
    wexp_t e;
    e.done  = (idx == 1250);
    e.layer = exp_layer(idx);
    e.word  = DW'(idx);
    return e;
  endfunction

  function automatic logic [127:0] all_outputs();
    return 128'({o_ready, o_weight_valid, o_weight_layer, o_weight, o_sync_done,
                 o_data_valid, o_data, o_q_valid, o_q});
  endfunction

  // Scoreboard drain: any output without a matching expectation is an error.
  always @(negedge clk) begin
    wexp_t e;
    if (o_weight_valid) begin
      wcount++;
      if (wq.size() == 0) check("spurious_weight", 128'(o_weight_valid), 128'd0);
      else begin
        e = wq.pop_front();
        check("weight_word", 128'(o_weight), 128'(e.word));
        check("weight_layer", 128'(o_weight_layer), 128'(e.layer));
        check("sync_done_flag", 128'(o_sync_done), 128'(e.done));
      end
    end else if (o_sync_done) begin
      check("sync_done_without_word", 128'(o_sync_done), 128'd0);
    end
    if (o_sync_done) done_cnt++;
    if (o_data_valid) begin
      dcount++;
      if (dq.size() == 0) check("spurious_data", 128'(o_data_valid), 128'd0);
      else check("data_word", 128'(o_data), 128'(dq.pop_front()));
    end
    if (o_q_valid) begin
      qcount++;
      if (qq.size() == 0) check("spurious_q", 128'(o_q_valid), 128'd0);
      else check("q_value", 128'(o_q), 128'(qq.pop_front()));
    end
  end

  initial begin
    int gap;
    rst            = 1'b1;
    i_sync_start   = 1'b0;
    i_src_valid    = 1'b0;
    i_src_weight   = '0;
    i_state_valid  = 1'b0;
    i_state        = '0;
    i_result_valid = 1'b0;
    i_result       = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 128'({1'b1, 102'd0}));
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", 128'(o_ready), 128'd1);

    // Gapless weight copy.
    i_sync_start = 1'b1;
    @(posedge clk); #1;
    i_sync_start = 1'b0;
    check("ready_low_in_sync", 128'(o_ready), 128'd0);
    wcount = 0; done_cnt = 0;
    for (int i = 0; i < 1251; i++) begin
      i_src_valid  = 1'b1;
      i_src_weight = DW'(i);
      wq.push_back(exp_word(i));
      @(posedge clk); #1;
    end
    i_src_valid = 1'b0;
    check("ready_at_sync_done", 128'(o_ready), 128'd1);
    @(posedge clk); #1;
    check("gapless_word_count", 128'(wcount), 128'd1251);
    check("gapless_done_count", 128'(done_cnt), 128'd1);
    check("weight_queue_drained", 128'(wq.size()), 128'd0);
    check("weight_hold_value", 128'(o_weight), 128'd1250);
    check("weight_valid_low", 128'(o_weight_valid), 128'd0);

    // Gapped copy with a state vector offered throughout and a stray restart.
    i_state       = {32'hDEAD0002, 32'hDEAD0001};
    i_state_valid = 1'b1;
    i_sync_start  = 1'b1;
    @(posedge clk); #1;
    i_sync_start = 1'b0;
    wcount = 0; done_cnt = 0;
    for (int i = 0; i < 1251; i++) begin
      if (i == 500) i_sync_start = 1'b1;
      i_src_valid  = 1'b1;
      i_src_weight = DW'(i);
      wq.push_back(exp_word(i));
      @(posedge clk); #1;
      i_sync_start = 1'b0;
      i_src_valid  = 1'b0;
      if (i != 1250) begin
        gap = int'($urandom_range(0, 3));
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    i_state_valid = 1'b0;
    check("ready_after_gapped", 128'(o_ready), 128'd1);
    repeat (2) @(posedge clk); #1;
    check("gapped_word_count", 128'(wcount), 128'd1251);
    check("gapped_done_count", 128'(done_cnt), 128'd1);
    check("gapped_no_data", 128'(dcount), 128'd0);

    // Spurious result in IDLE, then inference with a result during SEND.
    i_result_valid = 1'b1;
    i_result       = 32'h12345678;
    @(posedge clk); #1;
    i_result_valid = 1'b0;
    check("ready_after_idle_result", 128'(o_ready), 128'd1);
    i_state       = {32'h40000000, 32'h3F800000};
    i_state_valid = 1'b1;
    dq.push_back(32'h3F800000);
    dq.push_back(32'h40000000);
    @(posedge clk); #1;
    i_state_valid  = 1'b0;
    i_result_valid = 1'b1;
    i_result       = 32'hBADBAD00;
    check("ready_low_in_send", 128'(o_ready), 128'd0);
    @(posedge clk); #1;
    i_result_valid = 1'b0;
    check("ready_low_in_wait", 128'(o_ready), 128'd0);
    @(posedge clk); #1;
    i_result_valid = 1'b1;
    i_result       = 32'h41200000;
    qq.push_back(32'h41200000);
    @(posedge clk); #1;
    i_result_valid = 1'b0;
    check("ready_after_result", 128'(o_ready), 128'd1);
    @(posedge clk); #1;
    check("data_count", 128'(dcount), 128'd2);
    check("q_count", 128'(qcount), 128'd1);
    check("data_hold_value", 128'(o_data), 128'h40000000);
    check("data_queue_drained", 128'(dq.size()), 128'd0);

    // Simultaneous start: sync wins; a result pulse during SYNC is ignored.
    i_sync_start  = 1'b1;
    i_state_valid = 1'b1;
    i_state       = {32'hCAFE0002, 32'hCAFE0001};
    @(posedge clk); #1;
    i_sync_start  = 1'b0;
    i_state_valid = 1'b0;
    check("sync_wins_ready", 128'(o_ready), 128'd0);
    wcount = 0; done_cnt = 0;
    for (int i = 0; i < 1251; i++) begin
      i_src_valid    = 1'b1;
      i_src_weight   = DW'(i);
      i_result_valid = (i < 4);
      wq.push_back(exp_word(i));
      @(posedge clk); #1;
    end
    i_src_valid    = 1'b0;
    i_result_valid = 1'b0;
    @(posedge clk); #1;
    check("simul_word_count", 128'(wcount), 128'd1251);
    check("simul_no_data", 128'(dcount), 128'd2);
    check("simul_no_q", 128'(qcount), 128'd1);

    // Reset asserted mid-SEND.
    i_state       = {32'h00000BBB, 32'h00000AAA};
    i_state_valid = 1'b1;
    dq.push_back(32'h00000AAA);
    @(posedge clk); #1;
    i_state_valid = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), 128'({1'b1, 102'd0}));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("ready_after_release", 128'(o_ready), 128'd1);
    repeat (4) @(posedge clk); #1;
    check("reset_data_count", 128'(dcount), 128'd3);
    check("final_weight_queue", 128'(wq.size()), 128'd0);
    check("final_data_queue", 128'(dq.size()), 128'd0);
    check("final_q_queue", 128'(qq.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
